// File: rtl/data_mem_unit.sv
// data_mem_unit: MEM-stage RV32I load/store responder with a fixed multi-cycle access latency.
// Define DMEM_FAULT_EN to flag misaligned, undefined-funct3 and out-of-range requests.
module data_mem_unit #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        fault_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = LATENCY > 1 ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW+1:0]   addr_q, addr_d, addr_in;
    logic [1:0]      sz_q, sz_d, sz_in;
    logic            uns_q, uns_d, uns_in;
    logic            wr_q, wr_d;
    logic [31:0]     wdata_q, wdata_d, rdata_q, rdata_d;
    logic            busy_q, busy_d, done_q, done_d, fault_q, fault_d;
    logic            bad_f3, flt, fire;
    logic [31:0]     word, ld_val, wd;
    logic [15:0]     h;
    logic [7:0]      b;
    logic [3:0]      be;
    logic [31:0]     mem_q [DEPTH_WORDS];

    // Undefined size codes fall back to a word access.
    assign bad_f3 = funct3_i == 3'b011 || (funct3_i[2] && (funct3_i[1] || mem_write_i));
    assign sz_in  = bad_f3 ? 2'b10 : funct3_i[1:0];
    assign uns_in = funct3_i[2] & ~bad_f3;

`ifdef DMEM_FAULT_EN
    localparam logic [32:0] LIMIT = 33'(DEPTH_WORDS) << 2;
    logic misal, oor;
    assign misal   = (sz_in == 2'b01 && addr_i[0]) || (sz_in == 2'b10 && addr_i[1:0] != 2'b00);
    assign oor     = {1'b0, addr_i} >= LIMIT;
    assign flt     = bad_f3 | misal | oor;
    assign addr_in = addr_i[AW+1:0];
`else
    logic unused_hi;
    assign unused_hi = ^addr_i[31:AW+2];
    assign flt       = 1'b0;
    assign addr_in   = {addr_i[AW+1:2], addr_i[1] & ~sz_in[1], addr_i[0] & ~(|sz_in)};
`endif

    assign word   = mem_q[addr_q[AW+1:2]];
    assign b      = word[{addr_q[1:0], 3'b000} +: 8];
    assign h      = word[{addr_q[1], 4'b0000} +: 16];
    assign ld_val = sz_q == 2'b00 ? {{24{b[7] & ~uns_q}}, b} :
                    sz_q == 2'b01 ? {{16{h[15] & ~uns_q}}, h} : word;
    assign be     = sz_q == 2'b00 ? 4'b0001 << addr_q[1:0] :
                    sz_q == 2'b01 ? (addr_q[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wd     = sz_q == 2'b00 ? {4{wdata_q[7:0]}} :
                    sz_q == 2'b01 ? {2{wdata_q[15:0]}} : wdata_q;
    assign fire   = state_q == ACCESS && cnt_q == '0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sz_d    = sz_q;
        uns_d   = uns_q;
        wr_d    = wr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        fault_d = 1'b0;
        case (state_q)
            IDLE: if (mem_read_i || mem_write_i) begin
                addr_d  = addr_in;
                sz_d    = sz_in;
                uns_d   = uns_in;
                wr_d    = mem_write_i;
                wdata_d = wdata_i;
                cnt_d   = CW'(LATENCY - 1);
                state_d = flt ? DONE : ACCESS;
                fault_d = flt;
                rdata_d = flt && !mem_write_i ? '0 : rdata_q;
            end
            ACCESS: begin
                cnt_d   = fire ? cnt_q : cnt_q - CW'(1);
                state_d = fire ? DONE : ACCESS;
                rdata_d = fire && !wr_q ? ld_val : rdata_q;
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d == ACCESS;
        done_d = state_d == DONE;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            sz_q    <= '0;
            uns_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sz_q    <= sz_d;
            uns_q   <= uns_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fault_q <= fault_d;
        end
    end

    // Memory is never reset; a reset edge during ACCESS suppresses the pending store.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++)
            if (rst_n_i && fire && wr_q && be[i])
                mem_q[addr_q[AW+1:2]][8*i +: 8] <= wd[8*i +: 8];
    end

    assign rdata_o = rdata_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;
    assign fault_o = fault_q;
endmodule

// File: tb/tb_data_mem_unit.sv
// tb_data_mem_unit: directed load/store vectors for data_mem_unit, fault and non-fault builds.
module tb_data_mem_unit;
    logic        clk = 1'b0, rst_n = 1'b0, rd = 1'b0, wr = 1'b0;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] a = '0, wd = '0;
    logic [31:0] rdata;
    logic        busy, done, fault;
    int          errors = 0, checks = 0;

`ifdef DMEM_FAULT_EN
    localparam bit FE = 1'b1;
`else
    localparam bit FE = 1'b0;
`endif

    data_mem_unit #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .mem_read_i(rd), .mem_write_i(wr),
        .funct3_i(f3), .addr_i(a), .wdata_i(wd),
        .rdata_o(rdata), .busy_o(busy), .done_o(done), .fault_o(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request: edges from accept to done are 2 for a legal access, 0 for a fault.
    task automatic xact(input string tag, input logic r, input logic w, input logic [2:0] f,
                        input logic [31:0] ad, input logic [31:0] d, input logic exp_flt);
        int lat = 0;
        int nb  = 0;
        @(negedge clk);
        rd = r; wr = w; f3 = f; a = ad; wd = d;
        do begin
            @(negedge clk);
            lat++;
            nb += int'(busy);
        end while (!done && lat < 20);
        rd = 1'b0; wr = 1'b0;
        check({tag, " done"}, 32'(done), 32'd1);
        check({tag, " lat"}, 32'(lat - 1), exp_flt ? 32'd0 : 32'd2);
        check({tag, " busy"}, 32'(nb), exp_flt ? 32'd0 : 32'd2);
        check({tag, " fault"}, 32'(fault), 32'(exp_flt));
        @(negedge clk);
        check({tag, " pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst rdata", rdata, 32'h0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fault", 32'(fault), 32'd0);
        rst_n = 1'b1;

        xact("sw10", 1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
        xact("lw10", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw10 data", rdata, 32'hDEADBEEF);

        xact("sw10b", 1'b0, 1'b1, 3'b010, 32'h10, 32'h11223344, 1'b0);
        xact("sb13", 1'b0, 1'b1, 3'b000, 32'h13, 32'h123456AA, 1'b0);
        xact("lw10c", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw10c data", rdata, 32'hAA223344);
        xact("lb13", 1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
        check("lb13 data", rdata, 32'hFFFFFFAA);
        xact("lbu13", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        check("lbu13 data", rdata, 32'h000000AA);
        xact("lhu12", 1'b1, 1'b0, 3'b101, 32'h12, 32'h0, 1'b0);
        check("lhu12 data", rdata, 32'h0000AA22);
        xact("lh12", 1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
        check("lh12 data", rdata, 32'hFFFFAA22);

        xact("lh11", 1'b1, 1'b0, 3'b001, 32'h11, 32'h0, FE);
        check("lh11 data", rdata, FE ? 32'h0 : 32'h00003344);
        xact("lw10d", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw10d data", rdata, 32'hAA223344);
        xact("lw1010", 1'b1, 1'b0, 3'b010, 32'h1010, 32'h0, FE);
        check("lw1010 data", rdata, FE ? 32'h0 : 32'hAA223344);
        xact("lbu13b", 1'b1, 1'b0, 3'b100, 32'h13, 32'h0, 1'b0);
        check("lbu13b data", rdata, 32'h000000AA);
        xact("ld011", 1'b1, 1'b0, 3'b011, 32'h10, 32'h0, FE);
        check("ld011 data", rdata, FE ? 32'h0 : 32'hAA223344);

        xact("sh12", 1'b0, 1'b1, 3'b001, 32'h12, 32'hFFFF5566, 1'b0);
        xact("lw10e", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw10e data", rdata, 32'h55663344);
        xact("lb11", 1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
        check("lb11 data", rdata, 32'h00000033);
        xact("sw11", 1'b0, 1'b1, 3'b010, 32'h11, 32'h77777777, FE);
        xact("lw10f", 1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
        check("lw10f data", rdata, FE ? 32'h55663344 : 32'h77777777);

        xact("sw20", 1'b0, 1'b1, 3'b010, 32'h20, 32'h0BADF00D, 1'b0);
        @(negedge clk);
        wr = 1'b1; f3 = 3'b010; a = 32'h20; wd = 32'h12345678;
        @(negedge clk);
        check("abort busy", 32'(busy), 32'd1);
        rst_n = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("abort idle busy", 32'(busy), 32'd0);
        check("abort idle done", 32'(done), 32'd0);
        check("abort rdata", rdata, 32'h0);
        rst_n = 1'b1;
        xact("lw20", 1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
        check("lw20 data", rdata, 32'h0BADF00D);

        xact("both30", 1'b1, 1'b1, 3'b010, 32'h30, 32'hCAFEF00D, 1'b0);
        check("both30 rdata", rdata, 32'h0BADF00D);
        xact("lw30", 1'b1, 1'b0, 3'b010, 32'h30, 32'h0, 1'b0);
        check("lw30 data", rdata, 32'hCAFEF00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
